// File: rtl/perip_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// perip_pkg : shared types and encodings for the peripheral-bus arbiter
// Revision  : 1.0
// ============================================================================
package perip_pkg;

    localparam logic [1:0] MASK_B = 2'b00;
    localparam logic [1:0] MASK_H = 2'b01;
    localparam logic [1:0] MASK_W = 2'b10;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } arb_state_e;

    typedef logic [0:0] mst_id_t;

endpackage
`default_nettype wire

// File: rtl/perip_arbiter_if.sv
`default_nettype none
// ============================================================================
// perip_arbiter_if : two request ports plus the shared peripheral bus
// Revision         : 1.0
// ============================================================================
interface perip_arbiter_if;

    logic        m0_req;
    logic        m0_gnt;
    logic [31:0] m0_addr;
    logic        m0_wen;
    logic [1:0]  m0_mask;
    logic [31:0] m0_wdata;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_gnt;
    logic [31:0] m1_addr;
    logic        m1_wen;
    logic [1:0]  m1_mask;
    logic [31:0] m1_wdata;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic        m1_lock;

    logic [31:0] perip_addr;
    logic        perip_wen;
    logic [1:0]  perip_mask;
    logic [31:0] perip_wdata;
    logic [31:0] perip_rdata;

    // Arbiter side
    modport slave (
        input  m0_req, m0_addr, m0_wen, m0_mask, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_addr, m1_wen, m1_mask, m1_wdata, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output perip_addr, perip_wen, perip_mask, perip_wdata,
        input  perip_rdata
    );

    // Requesters and peripheral side
    modport master (
        output m0_req, m0_addr, m0_wen, m0_mask, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_addr, m1_wen, m1_mask, m1_wdata, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  perip_addr, perip_wen, perip_mask, perip_wdata,
        output perip_rdata
    );

endinterface
`default_nettype wire

// File: rtl/perip_arbiter_rsp_pipe.sv
`default_nettype none
// ============================================================================
// rsp_pipe : DEPTH-stage {valid, id} shift register tracking issued reads
// Revision : 1.0
// ============================================================================
module rsp_pipe
    import perip_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  wire logic    clk,
    input  wire logic    rst,
    input  wire logic    i_valid,
    input  wire mst_id_t i_id,
    output logic         o_valid,
    output mst_id_t      o_id
);

    logic    [DEPTH-1:0] r_valid;
    mst_id_t             r_id [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_id[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_id[0]    <= i_id;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_id[i]    <= r_id[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_id    = r_id[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/perip_arbiter.sv
`default_nettype none
// ============================================================================
// perip_arbiter : two-master arbiter for the peripheral bus with an
//                 anti-starvation age counter and a master 1 bus lock
// Revision      : 1.0
// ============================================================================
module perip_arbiter
    import perip_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  wire logic     cpu_clk,
    input  wire logic     cpu_rst,
    perip_arbiter_if.slave bus
);

    localparam logic [0:0] c_ST_ARB       = 1'(ARB);
    localparam logic [0:0] c_ST_LOCK1     = 1'(LOCK1);
    localparam logic [7:0] c_STARVE_MAX   = 8'(STARVE_MAX);

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [7:0] r_starve_cnt;

    logic       w_lock_hold;
    logic       w_m0_gnt;
    logic       w_m1_gnt;
    logic       w_any_gnt;
    logic       w_sel_wen;
    logic       w_rd_issue;
    logic       w_rsp_valid;
    mst_id_t    w_rsp_id;

    // A lock only persists while master 1 keeps both req and lock high;
    // otherwise this very cycle is arbitrated normally.
    assign w_lock_hold = (r_state == c_ST_LOCK1) & bus.m1_req & bus.m1_lock;

    assign w_m1_gnt  = ~cpu_rst & bus.m1_req &
                       (w_lock_hold | ~bus.m0_req | (r_starve_cnt == c_STARVE_MAX));
    assign w_m0_gnt  = ~cpu_rst & bus.m0_req & ~w_m1_gnt;
    assign w_any_gnt = w_m0_gnt | w_m1_gnt;

    assign w_state_nxt = (w_m1_gnt & bus.m1_lock) ? c_ST_LOCK1 : c_ST_ARB;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state      <= c_ST_ARB;
            r_starve_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_m1_gnt) begin
                r_starve_cnt <= '0;
            end else if (bus.m1_req && (r_starve_cnt != c_STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end
        end
    end

    assign w_sel_wen       = w_m1_gnt ? bus.m1_wen : bus.m0_wen;

    assign bus.m0_gnt      = w_m0_gnt;
    assign bus.m1_gnt      = w_m1_gnt;
    assign bus.perip_addr  = w_m1_gnt ? bus.m1_addr  : bus.m0_addr;
    assign bus.perip_mask  = w_m1_gnt ? bus.m1_mask  : bus.m0_mask;
    assign bus.perip_wdata = w_m1_gnt ? bus.m1_wdata : bus.m0_wdata;
    assign bus.perip_wen   = w_any_gnt & w_sel_wen;

    assign w_rd_issue = w_any_gnt & ~w_sel_wen;

    rsp_pipe #(
        .DEPTH (RD_LAT)
    ) u_rsp_pipe (
        .clk     (cpu_clk),
        .rst     (cpu_rst),
        .i_valid (w_rd_issue),
        .i_id    (mst_id_t'(w_m1_gnt)),
        .o_valid (w_rsp_valid),
        .o_id    (w_rsp_id)
    );

    // Gating with reset keeps a response due in the reset cycle from escaping.
    assign bus.m0_rvalid = ~cpu_rst & w_rsp_valid & (w_rsp_id == 1'b0);
    assign bus.m1_rvalid = ~cpu_rst & w_rsp_valid & (w_rsp_id == 1'b1);
    assign bus.m0_rdata  = bus.perip_rdata;
    assign bus.m1_rdata  = bus.perip_rdata;

endmodule
`default_nettype wire

// File: tb/tb_perip_arbiter.sv
`default_nettype none
// ============================================================================
// tb_perip_arbiter : randomized and directed scoreboard bench, RD_LAT 1 and 3
// Revision         : 1.0
// ============================================================================
module tb_perip_arbiter;
    import perip_pkg::*;

    localparam int STARVE_MAX = 8;

    typedef struct {
        bit          req;
        logic [31:0] addr;
        bit          wen;
        logic [1:0]  mask;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct {
        bit          g0;
        bit          g1;
        bit          wen;
        logic [31:0] addr;
        logic [1:0]  mask;
        logic [31:0] wdata;
    } exp_t;

    logic clk = 1'b0;
    logic cpu_rst;
    always #5 clk = ~clk;

    perip_arbiter_if if1 ();
    perip_arbiter_if if3 ();

    assign if3.m0_req      = if1.m0_req;
    assign if3.m0_addr     = if1.m0_addr;
    assign if3.m0_wen      = if1.m0_wen;
    assign if3.m0_mask     = if1.m0_mask;
    assign if3.m0_wdata    = if1.m0_wdata;
    assign if3.m1_req      = if1.m1_req;
    assign if3.m1_addr     = if1.m1_addr;
    assign if3.m1_wen      = if1.m1_wen;
    assign if3.m1_mask     = if1.m1_mask;
    assign if3.m1_wdata    = if1.m1_wdata;
    assign if3.m1_lock     = if1.m1_lock;
    assign if3.perip_rdata = if1.perip_rdata;

    perip_arbiter #(.RD_LAT(1), .STARVE_MAX(STARVE_MAX)) u_dut1 (
        .cpu_clk (clk),
        .cpu_rst (cpu_rst),
        .bus     (if1)
    );

    perip_arbiter #(.RD_LAT(3), .STARVE_MAX(STARVE_MAX)) u_dut3 (
        .cpu_clk (clk),
        .cpu_rst (cpu_rst),
        .bus     (if3)
    );

    int      n_cmp = 0;
    int      n_bad = 0;
    int      cyc   = 0;
    bit      done  = 1'b0;
    exp_t    q_exp [$];
    bit [1:0] exp1 [8192];   // {valid, id} expected per cycle, latency 1
    bit [1:0] exp3 [8192];   // same, latency 3

    // Reference state: whether master 1 currently holds the bus, and how long it has waited
    bit      m_locked = 1'b0;
    int      m_wait   = 0;
    bit      last_g0, last_g1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, req);
        end
    endtask

    task automatic chk_side(input string t, input logic g0, input logic g1, input logic wen,
                            input logic [31:0] addr, input logic [1:0] mask,
                            input logic [31:0] wdata, input exp_t e);
        chk({t, "_m0_gnt"},  32'(g0), 32'(e.g0));
        chk({t, "_m1_gnt"},  32'(g1), 32'(e.g1));
        chk({t, "_wen"},     32'(wen), 32'(e.wen));
        chk({t, "_addr"},    addr, e.addr);
        chk({t, "_mask"},    32'(mask), 32'(e.mask));
        chk({t, "_wdata"},   wdata, e.wdata);
    endtask

    function automatic mreq_t mk(input bit rq, input logic [31:0] a, input bit w,
                                 input logic [1:0] m, input logic [31:0] d);
        mreq_t r;
        r.req = rq; r.addr = a; r.wen = w; r.mask = m; r.wdata = d;
        return r;
    endfunction

    function automatic mreq_t rnd_req();
        return mk($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 2)), $urandom);
    endfunction

    // Drive one cycle, predict its outcome, queue the expectation, advance the clock.
    task automatic step(input bit r, input mreq_t a, input mreq_t b, input bit lk);
        exp_t e;
        bit   g0, g1, hold;
        if1.m0_req = a.req; if1.m0_addr = a.addr; if1.m0_wen = a.wen;
        if1.m0_mask = a.mask; if1.m0_wdata = a.wdata;
        if1.m1_req = b.req; if1.m1_addr = b.addr; if1.m1_wen = b.wen;
        if1.m1_mask = b.mask; if1.m1_wdata = b.wdata;
        if1.m1_lock = lk;
        if1.perip_rdata = $urandom;
        cpu_rst = r;
        if (r) begin
            g0 = 1'b0; g1 = 1'b0;
            m_locked = 1'b0; m_wait = 0;
            for (int k = cyc; k < cyc + 8; k++) begin
                exp1[k] = 2'b00;
                exp3[k] = 2'b00;
            end
        end else begin
            hold = m_locked && b.req && lk;
            g1   = b.req && (hold || !a.req || m_wait >= STARVE_MAX);
            g0   = a.req && !g1;
            if (g1) begin
                m_wait   = 0;
                m_locked = lk;
            end else begin
                m_locked = 1'b0;
                if (b.req && m_wait < STARVE_MAX) m_wait++;
            end
            if ((g0 && !a.wen) || (g1 && !b.wen)) begin
                exp1[cyc + 1] = {1'b1, g1};
                exp3[cyc + 3] = {1'b1, g1};
            end
        end
        e.g0    = g0;
        e.g1    = g1;
        e.addr  = g1 ? b.addr  : a.addr;
        e.mask  = g1 ? b.mask  : a.mask;
        e.wdata = g1 ? b.wdata : a.wdata;
        e.wen   = g1 ? b.wen : (g0 ? a.wen : 1'b0);
        q_exp.push_back(e);
        last_g0 = g0;
        last_g1 = g1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Monitor: compares bus outputs and read responses at mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) break;
            if (q_exp.size() != 0) begin
                e = q_exp.pop_front();
                chk_side("L1", if1.m0_gnt, if1.m1_gnt, if1.perip_wen, if1.perip_addr,
                         if1.perip_mask, if1.perip_wdata, e);
                chk_side("L3", if3.m0_gnt, if3.m1_gnt, if3.perip_wen, if3.perip_addr,
                         if3.perip_mask, if3.perip_wdata, e);
            end
            chk("L1_m0_rvalid", 32'(if1.m0_rvalid), 32'(exp1[cyc] == 2'b10));
            chk("L1_m1_rvalid", 32'(if1.m1_rvalid), 32'(exp1[cyc] == 2'b11));
            chk("L3_m0_rvalid", 32'(if3.m0_rvalid), 32'(exp3[cyc] == 2'b10));
            chk("L3_m1_rvalid", 32'(if3.m1_rvalid), 32'(exp3[cyc] == 2'b11));
            if (exp1[cyc][1]) chk("L1_rdata", exp1[cyc][0] ? if1.m1_rdata : if1.m0_rdata, if1.perip_rdata);
            if (exp3[cyc][1]) chk("L3_rdata", exp3[cyc][0] ? if3.m1_rdata : if3.m0_rdata, if1.perip_rdata);
        end
    end

    initial begin
        mreq_t idle, pa, pb;
        idle = mk(1'b0, 32'h0, 1'b0, MASK_B, 32'h0);
        cpu_rst = 1'b1;
        @(posedge clk);
        #1;

        step(1'b1, idle, idle, 1'b0);
        step(1'b1, idle, idle, 1'b0);

        // Master 0 alone: word read
        step(1'b0, mk(1'b1, 32'h8000_0010, 1'b0, MASK_W, 32'h0), idle, 1'b0);
        step(1'b0, idle, idle, 1'b0);
        step(1'b0, idle, idle, 1'b0);
        step(1'b0, idle, idle, 1'b0);

        // Continuous contention: 8 x m0 then 1 x m1, three periods
        for (int i = 0; i < 27; i++)
            step(1'b0, mk(1'b1, 32'h1000_0000 + 32'(i * 4), 1'b0, MASK_W, 32'h0),
                 mk(1'b1, 32'h2000_0000, 1'b0, MASK_W, 32'h0), 1'b0);

        // Locked writes from master 1 against a requesting master 0, then lock drop
        for (int i = 0; i < 12; i++)
            step(1'b0, mk(1'b1, 32'h1100_0000 + 32'(i * 4), 1'b0, MASK_W, 32'h0),
                 mk(1'b1, 32'h3000_0000, 1'b1, MASK_W, 32'hCAFE_0000), 1'b1);
        step(1'b0, mk(1'b1, 32'h1200_0000, 1'b0, MASK_W, 32'h0),
             mk(1'b1, 32'h3000_0004, 1'b1, MASK_W, 32'hCAFE_0001), 1'b0);
        step(1'b0, idle, idle, 1'b0);

        // Alternating single reads
        step(1'b0, mk(1'b1, 32'h0000_0100, 1'b0, MASK_W, 32'h0), idle, 1'b0);
        step(1'b0, idle, mk(1'b1, 32'h0000_0200, 1'b0, MASK_H, 32'h0), 1'b0);
        step(1'b0, mk(1'b1, 32'h0000_0300, 1'b0, MASK_B, 32'h0), idle, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, idle, idle, 1'b0);

        // Reset with two reads outstanding
        step(1'b0, mk(1'b1, 32'h0000_0400, 1'b0, MASK_W, 32'h0), idle, 1'b0);
        step(1'b0, idle, mk(1'b1, 32'h0000_0500, 1'b0, MASK_W, 32'h0), 1'b0);
        step(1'b1, mk(1'b1, 32'h0000_0600, 1'b1, MASK_W, 32'h1), idle, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, idle, idle, 1'b0);

        // Byte write from master 1
        step(1'b0, idle, mk(1'b1, 32'h4000_0001, 1'b1, MASK_B, 32'h0000_00AB), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, idle, idle, 1'b0);

        // Random traffic; each master holds its request until granted
        pa = idle;
        pb = idle;
        for (int i = 0; i < 400; i++) begin
            if (!pa.req || last_g0) pa = rnd_req();
            if (!pb.req || last_g1) pb = rnd_req();
            step($urandom_range(0, 99) == 0, pa, pb, $urandom_range(0, 2) == 0);
        end
        for (int i = 0; i < 5; i++) step(1'b0, idle, idle, 1'b0);

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
